// File: rtl/gray_decoder.sv
// gray_decoder: receive-side Gray-code count checker.
// Converts a qualified Gray-coded count stream to binary and verifies that
// each accepted sample holds or advances the count by exactly one. A wrap
// from all-ones to zero sets a sticky Overflow. Any other jump latches Error
// and parks the FSM in FAULT until Reset.
module gray_decoder #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [WIDTH-1:0] Gray,
  output logic [WIDTH-1:0] Binary,
  output logic             Locked,
  output logic             Overflow,
  output logic             Error
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] binary_q, binary_d;
  logic             locked_q, locked_d;
  logic             overflow_q, overflow_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] binary_inc;

  // MSB passes through; each lower bit is the XOR of the decoded bit above
  // it with the matching Gray bit.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Decode the incoming code and form the expected successor (wraps mod 2^WIDTH).
  always_comb begin
    dec        = gray_to_bin(Gray);
    binary_inc = binary_q + 1'b1;
  end

  // Next-state logic: lock, hold/advance checks, and fault capture.
  always_comb begin
    state_d    = state_q;
    binary_d   = binary_q;
    overflow_d = overflow_q;
    error_d    = error_q;

    if (Valid) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          // Any code is an acceptable lock point.
          binary_d = dec;
          state_d  = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (dec == binary_q) begin
            // Hold is legal; nothing changes.
          end else if (dec == binary_inc) begin
            binary_d = dec;
            if (&binary_q) begin
              overflow_d = 1'b1;
            end
          end else begin
            // Illegal jump: keep the last good value, even for wrap-like jumps.
            error_d = 1'b1;
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          // Stream ignored until Reset.
        end
        default: begin
          state_d = ST_FAULT;
          error_d = 1'b1;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers, cleared immediately by Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_UNLOCKED;
      binary_q   <= '0;
      locked_q   <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      binary_q   <= binary_d;
      locked_q   <= locked_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

  assign Binary   = binary_q;
  assign Locked   = locked_q;
  assign Overflow = overflow_q;
  assign Error    = error_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Bench for gray_decoder: directed scenarios with constant expectations,
// then a randomized stream checked against a behavioural model.
module tb_gray_decoder;

  localparam int W    = 3;
  localparam int NMAX = 1 << W;

  logic         Clk;
  logic         Reset;
  logic         Valid;
  logic [W-1:0] Gray;
  logic [W-1:0] Binary;
  logic         Locked;
  logic         Overflow;
  logic         Error;

  int n_checks;
  int n_errors;

  // Behavioural model: 0 = unlocked, 1 = locked, 2 = fault
  int m_state;
  int m_bin;
  int m_ovf;

  gray_decoder #(.WIDTH(W)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Valid(Valid),
    .Gray(Gray),
    .Binary(Binary),
    .Locked(Locked),
    .Overflow(Overflow),
    .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  // Gray code of a count value.
  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % NMAX;
  endfunction

  // Binary count whose Gray code equals g, found by search.
  function automatic int from_gray(input int g);
    for (int b = 0; b < NMAX; b++) begin
      if (to_gray(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_bin   = 0;
    m_ovf   = 0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] g);
    int d;
    if (v !== 1'b1) return;
    d = from_gray(int'(g));
    if (m_state == 0) begin
      m_bin   = d;
      m_state = 1;
    end else if (m_state == 1) begin
      if (d == m_bin) begin
      end else if (d == (m_bin + 1) % NMAX) begin
        if (m_bin == NMAX - 1) m_ovf = 1;
        m_bin = d;
      end else begin
        m_state = 2;
      end
    end
  endtask

  // Drive one sample on the falling edge, then move past the rising edge.
  task automatic cycle(input logic v, input logic [W-1:0] g);
    @(negedge Clk);
    Valid = v;
    Gray  = g;
    @(posedge Clk);
    #1;
    model_step(v, g);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got bin=%0d lk=%b ov=%b er=%b, want 0 0 0 0",
               Binary, Locked, Overflow, Error);
    end
  endtask

  task automatic test_count_wrap();
    logic [W-1:0] codes [0:7];
    codes = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, codes[i]);
      n_checks++;
      if ({Binary, Locked, Overflow, Error} !== {3'(i), 1'b1, 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL count_%0d: got bin=%0d lk=%b ov=%b er=%b, want %0d 1 0 0",
                 i, Binary, Locked, Overflow, Error, i);
      end
    end
    cycle(1'b1, 3'b000);
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL wrap_edge: got bin=%0d lk=%b ov=%b er=%b, want 0 1 1 0",
               Binary, Locked, Overflow, Error);
    end
    cycle(1'b1, 3'b001);
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd1, 1'b1, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL after_wrap: got bin=%0d lk=%b ov=%b er=%b, want 1 1 1 0",
               Binary, Locked, Overflow, Error);
    end
  endtask

  task automatic test_hold_idle();
    do_reset();
    cycle(1'b1, 3'b011);
    cycle(1'b1, 3'b011);
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd2, 1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL hold: got bin=%0d lk=%b ov=%b er=%b, want 2 1 0 0",
               Binary, Locked, Overflow, Error);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'b101);
      n_checks++;
      if ({Binary, Locked, Overflow, Error} !== {3'd2, 1'b1, 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL idle_%0d: got bin=%0d lk=%b ov=%b er=%b, want 2 1 0 0",
                 i, Binary, Locked, Overflow, Error);
      end
    end
    cycle(1'b1, 3'b010);
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd3, 1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL resume: got bin=%0d lk=%b ov=%b er=%b, want 3 1 0 0",
               Binary, Locked, Overflow, Error);
    end
  endtask

  task automatic test_backward();
    do_reset();
    cycle(1'b1, 3'b011);
    cycle(1'b1, 3'b001);
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd2, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL backward: got bin=%0d lk=%b ov=%b er=%b, want 2 0 0 1",
               Binary, Locked, Overflow, Error);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    cycle(1'b1, 3'b001);
    cycle(1'b1, 3'b010);
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd1, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL illegal_jump: got bin=%0d lk=%b ov=%b er=%b, want 1 0 0 1",
               Binary, Locked, Overflow, Error);
    end
    cycle(1'b1, 3'b011);
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd1, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL fault_ignores: got bin=%0d lk=%b ov=%b er=%b, want 1 0 0 1",
               Binary, Locked, Overflow, Error);
    end
  endtask

  task automatic test_wrap_like_illegal();
    // Walk to 7 then jump to 1: an error, never an overflow.
    do_reset();
    cycle(1'b1, 3'b100);
    cycle(1'b1, 3'b001);
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd7, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL wrap_like_jump: got bin=%0d lk=%b ov=%b er=%b, want 7 0 0 1",
               Binary, Locked, Overflow, Error);
    end
  endtask

  task automatic test_async_reset();
    // Start from the fault left by test_illegal.
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL async_reset: got bin=%0d lk=%b ov=%b er=%b, want 0 0 0 0",
               Binary, Locked, Overflow, Error);
    end
    // A Valid edge while Reset is held must be discarded.
    Valid = 1'b1;
    Gray  = 3'b110;
    @(posedge Clk);
    #1;
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_priority: got bin=%0d lk=%b ov=%b er=%b, want 0 0 0 0",
               Binary, Locked, Overflow, Error);
    end
    @(negedge Clk);
    Valid = 1'b0;
    Reset = 1'b0;
    model_reset();
    cycle(1'b1, 3'b110);
    n_checks++;
    if ({Binary, Locked, Overflow, Error} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL relock: got bin=%0d lk=%b ov=%b er=%b, want 4 1 0 0",
               Binary, Locked, Overflow, Error);
    end
  endtask

  task automatic test_random();
    int r, sel, b;
    logic v;
    logic [W-1:0] g;
    do_reset();
    for (int it = 0; it < 600; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset();
      end else begin
        v = (r < 85);
        sel = int'($urandom_range(0, 19));
        if (m_state == 1 && sel < 12)      b = (m_bin + 1) % NMAX;
        else if (m_state == 1 && sel < 17) b = m_bin;
        else                               b = int'($urandom_range(0, NMAX - 1));
        g = W'(to_gray(b));
        if (!v && $urandom_range(0, 1) == 1) g = 'x;
        cycle(v, g);
      end
      n_checks++;
      if ({Binary, Locked, Overflow, Error} !==
          {W'(m_bin), (m_state == 1), (m_ovf == 1), (m_state == 2)}) begin
        n_errors++;
        $display("FAIL random_%0d: got bin=%0d lk=%b ov=%b er=%b, want %0d %0d %0d %0d",
                 it, Binary, Locked, Overflow, Error,
                 m_bin, (m_state == 1), m_ovf, (m_state == 2));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b0;
    Valid = 1'b0;
    Gray  = '0;
    model_reset();
    test_reset();
    test_count_wrap();
    test_hold_idle();
    test_backward();
    test_wrap_like_illegal();
    test_illegal();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
